serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing D = A − B, LSB first, one bit per clock. It uses a single `full_subtractor` cell and a registered borrow. It is the inverse-direction companion to the team's adder cells and serves area-constrained datapaths where a WIDTH-bit ripple subtractor is too large. Operands enter and results leave over valid/ready handshakes.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal values are ≥ 2.
- `clk_i`  input  1  single clock; all state updates on its rising edge.
- `rst_ni`  input  1  reset, asynchronous and active-low.
- `in_valid_i`  input  1  operand pair valid.
- `in_ready_o`  output  1  block can accept an operand pair.
- `a_i`  input  WIDTH  minuend.
- `b_i`  input  WIDTH  subtrahend.
- `out_valid_o`  output  1  result valid.
- `out_ready_i`  input  1  consumer accepts the result.
- `d_o`  output  WIDTH  difference, A − B mod 2^WIDTH.
- `borrow_o`  output  1  final borrow out; 1 when A < B as unsigned values.
- `overflow_o`  output  1  signed overflow of A − B in two's complement.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `in_ready_o` = 1.
  - On `in_valid_i && in_ready_o`: latch `a_i` and `b_i` into shift registers, clear the borrow flop, set the bit counter to 0, go to RUN.
- **RUN**
  - `in_ready_o` = 0; `in_valid_i` is ignored.
  - Each cycle the cell takes a_sr[0], b_sr[0] and borrow_q.
    - Difference bit = a ^ b ^ bin.
    - Borrow out = (~a & b) | (~(a ^ b) & bin).
  - The difference bit shifts into the MSB of d_sr (right shift). a_sr and b_sr shift right. borrow_q takes the borrow out.
  - When the counter reaches WIDTH−1, go to DONE after that cycle's update.
- **DONE**
  - `out_valid_o` = 1.
  - `d_o` = d_sr and `borrow_o` = borrow_q, both held stable.
  - `overflow_o` = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]). A[MSB] and B[MSB] are captured at accept.
  - On `out_ready_i`: go to IDLE.
- Outputs are 0 whenever `out_valid_o` = 0. `d_o`, `borrow_o` and `overflow_o` are masked to 0 outside DONE.
- The counter is $clog2(WIDTH) bits wide and does not wrap during an operation.

## Timing
- Reset values:
  - State = IDLE.
  - `in_ready_o` = 1.
  - `out_valid_o` = 0, `d_o` = 0, `borrow_o` = 0, `overflow_o` = 0.
  - All shift registers, the counter and borrow_q = 0.
- Let edge 0 be the clock edge where the input handshake fires.
  - RUN covers cycles 1..WIDTH.
  - `out_valid_o` first rises after edge WIDTH, giving a latency of WIDTH+1 cycles from accept to valid.
- Back-to-back throughput is one operation per WIDTH+2 cycles:
  - the DONE→IDLE transition costs one cycle;
  - there is no accept in the same cycle as the output handshake.
- Backpressure: with `out_ready_i` held at 0, DONE holds indefinitely and all outputs stay stable.
- Reset asserted at any point, including mid-RUN, returns all state and outputs to their reset values immediately (asynchronously). The partial result is discarded. No output handshake occurs for the aborted operation.
- `in_valid_i` asserted during RUN or DONE has no effect and is not latched.

## Structure
- Package `serial_subtractor_pkg` holds the `state_e` enum typedef (IDLE, RUN, DONE).
- Sub-module `full_subtractor`:
  - ports `a_i`, `b_i`, `c_i` (borrow in), `s_o` (difference), `c_o` (borrow out);
  - purely combinational; one instance.
- Top level contains the FSM, the counter, the three shift registers, the borrow flop and the overflow logic.

## Test plan
- WIDTH=8, A=0x05, B=0x03 → after 9 cycles `d_o`=0x02, `borrow_o`=0, `overflow_o`=0.
- A=0x03, B=0x05 → `d_o`=0xFE, `borrow_o`=1, `overflow_o`=0.
- A=0x80, B=0x01 → `d_o`=0x7F, `borrow_o`=0, `overflow_o`=1.
- A=0x7F, B=0xFF → `d_o`=0x80, `borrow_o`=1, `overflow_o`=1.
- Backpressure:
  - hold `out_ready_i`=0 for 20 cycles → outputs stable at the correct value;
  - toggle `in_valid_i` with new operands during the hold → not accepted;
  - release `out_ready_i` → IDLE next cycle, `in_ready_o`=1.
- Reset mid-run: pulse `rst_ni` low during RUN cycle 4 → all outputs 0 immediately, `in_ready_o`=1 after release. A following A=0xAA, B=0x55 → `d_o`=0x55, `borrow_o`=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle; slave is the subtractor, master the producer/consumer.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] d_o;
    logic             borrow_o;
    logic             overflow_o;

    modport slave (
        input  in_valid_i, a_i, b_i, out_ready_i,
        output in_ready_o, out_valid_o, d_o, borrow_o, overflow_o
    );

    modport master (
        output in_valid_i, a_i, b_i, out_ready_i,
        input  in_ready_o, out_valid_o, d_o, borrow_o, overflow_o
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: c_i/c_o carry the borrow.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (~a_i & b_i) | (~(a_i ^ b_i) & c_i);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B, LSB first, one bit per clock through a single full_subtractor.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_diff;
    logic             w_bout;

    full_subtractor u_cell (
        .a_i (r_a_sr[0]),
        .b_i (r_b_sr[0]),
        .c_i (r_borrow),
        .s_o (w_diff),
        .c_o (w_bout)
    );

    assign w_accept = (r_state == IDLE) && bus.in_valid_i;
    assign w_run    = (r_state == RUN);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        bus.in_ready_o  = 1'b0;
        bus.out_valid_o = 1'b0;
        bus.d_o         = '0;
        bus.borrow_o    = 1'b0;
        bus.overflow_o  = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready_o = 1'b1;
                if (bus.in_valid_i) w_state_next = RUN;
            end
            RUN: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                bus.out_valid_o = 1'b1;
                bus.d_o         = r_d_sr;
                bus.borrow_o    = r_borrow;
                // Signed overflow: operand signs differ and the result sign disagrees with A.
                bus.overflow_o  = (r_a_msb != r_b_msb) && (r_d_sr[WIDTH-1] != r_a_msb);
                if (bus.out_ready_i) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_d_sr   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
        end else if (w_accept) begin
            r_a_sr   <= bus.a_i;
            r_b_sr   <= bus.b_i;
            r_d_sr   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_a_msb  <= bus.a_i[WIDTH-1];
            r_b_msb  <= bus.b_i[WIDTH-1];
        end else if (w_run) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_d_sr   <= {w_diff, r_d_sr[WIDTH-1:1]};
            r_borrow <= w_bout;
            // Counter parks at WIDTH-1 rather than wrapping.
            if (!w_last) r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) using immediate assertions.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an operand pair at a falling edge; returns at the falling edge after acceptance.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_accept", {31'd0, bus.in_ready_o}, 32'd1);
        bus.a_i        = a;
        bus.b_i        = b;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        check("in_ready_in_run", {31'd0, bus.in_ready_o}, 32'd0);
    endtask

    // Wait for out_valid; counts falling edges after the accepting edge.
    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        int n;
        start_op(a, b);
        wait_valid(n);
        check({tag, "_latency"}, n, W);
        check({tag, "_d"}, {24'd0, bus.d_o}, {24'd0, ed});
        check({tag, "_borrow"}, {31'd0, bus.borrow_o}, {31'd0, eb});
        check({tag, "_overflow"}, {31'd0, bus.overflow_o}, {31'd0, eo});
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        check({tag, "_idle_valid"}, {31'd0, bus.out_valid_o}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, bus.in_ready_o}, 32'd1);
        check({tag, "_idle_d"}, {24'd0, bus.d_o}, 32'd0);
    endtask

    initial begin
        int n;
        vectors         = 0;
        miscompares     = 0;
        rst_n           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.out_ready_i = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("rst_d", {24'd0, bus.d_o}, 32'd0);
        check("rst_borrow", {31'd0, bus.borrow_o}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow_o}, 32'd0);
        rst_n = 1'b1;

        run_op("v05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("v03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op("v80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("v7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Backpressure: 0x10 - 0x20 = 0xF0, borrow, no overflow.
        start_op(8'h10, 8'h20);
        wait_valid(n);
        check("bp_latency", n, W);
        for (int i = 0; i < 20; i++) begin
            bus.a_i        = 8'hC3 ^ 8'(i);
            bus.b_i        = 8'h3C + 8'(i);
            bus.in_valid_i = i[0];
            @(negedge clk);
            check("bp_valid", {31'd0, bus.out_valid_o}, 32'd1);
            check("bp_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
            check("bp_d", {24'd0, bus.d_o}, 32'hF0);
            check("bp_borrow", {31'd0, bus.borrow_o}, 32'd1);
            check("bp_overflow", {31'd0, bus.overflow_o}, 32'd0);
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        check("bp_release_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("bp_release_ready", {31'd0, bus.in_ready_o}, 32'd1);
        repeat (3) @(negedge clk);
        check("bp_no_latch_valid", {31'd0, bus.out_valid_o}, 32'd0);

        // Reset during RUN cycle 4 aborts the operation.
        start_op(8'h33, 8'h11);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("mid_rst_d", {24'd0, bus.d_o}, 32'd0);
        check("mid_rst_borrow", {31'd0, bus.borrow_o}, 32'd0);
        check("mid_rst_overflow", {31'd0, bus.overflow_o}, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid_o) n++;
        end
        check("post_rst_no_result", n, 0);

        run_op("vAA_55", 8'hAA, 8'h55, 8'h55, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
